// File: rtl/avmm_cordic_master_if.sv
// Command/result stream plus Avalon-MM register bus between the sequencer, the
// master and the compute slave.
interface avmm_cordic_master_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_angle;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_fn1;
  logic [WIDTH-1:0] res_fn2;
  logic [1:0]       res_err;
  logic             busy;
  logic             chipselect;
  logic             write_n;
  logic [2:0]       address;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    input  cmd_valid, cmd_angle, res_ready, readdata,
    output cmd_ready, res_valid, res_fn1, res_fn2, res_err, busy,
           chipselect, write_n, address, writedata
  );

  modport slave (
    output cmd_valid, cmd_angle, res_ready, readdata,
    input  cmd_ready, res_valid, res_fn1, res_fn2, res_err, busy,
           chipselect, write_n, address, writedata
  );
endinterface

// File: rtl/avmm_cordic_master.sv
// Avalon-MM initiator: per command writes/verifies the angle, starts the slave,
// polls done, reads fn1/fn2, clears done and hands the result downstream.
module avmm_cordic_master #(
  parameter int WIDTH     = 32,
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  avmm_cordic_master_if.master bus
);
  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 2);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  localparam logic [2:0] A_ANGLE = 3'd0;
  localparam logic [2:0] A_START = 3'd1;
  localparam logic [2:0] A_FN1   = 3'd2;
  localparam logic [2:0] A_FN2   = 3'd3;
  localparam logic [2:0] A_DONE  = 3'd4;

  typedef enum logic [3:0] {
    IDLE, WR_N, RD_N, WR_START, POLL, GAP, RD_FN1, RD_FN2, CLR, OUT
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]  angle_q, angle_nxt;
  logic [WIDTH-1:0]  fn1_q, fn1_nxt;
  logic [WIDTH-1:0]  fn2_q, fn2_nxt;
  logic [1:0]        err_q, err_nxt;
  logic [POLL_W-1:0] poll_cnt, poll_cnt_nxt, poll_inc;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              cs_q, cs_nxt;
  logic              wn_q, wn_nxt;
  logic [2:0]        addr_q, addr_nxt;
  logic [WIDTH-1:0]  wd_q, wd_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      err_q    <= '0;
      fn1_q    <= '0;
      fn2_q    <= '0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= '0;
      wd_q     <= '0;
    end else begin
      state    <= state_nxt;
      poll_cnt <= poll_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      err_q    <= err_nxt;
      fn1_q    <= fn1_nxt;
      fn2_q    <= fn2_nxt;
      cs_q     <= cs_nxt;
      wn_q     <= wn_nxt;
      addr_q   <= addr_nxt;
      wd_q     <= wd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    angle_q <= angle_nxt;
  end

  always_comb begin
    state_nxt    = state;
    angle_nxt    = angle_q;
    fn1_nxt      = fn1_q;
    fn2_nxt      = fn2_q;
    err_nxt      = err_q;
    poll_cnt_nxt = poll_cnt;
    gap_cnt_nxt  = gap_cnt;
    poll_inc     = poll_cnt + 1'b1;
    cs_nxt       = 1'b0;
    wn_nxt       = 1'b1;
    addr_nxt     = A_ANGLE;
    wd_nxt       = '0;

    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          angle_nxt = bus.cmd_angle;
          fn1_nxt   = '0;
          fn2_nxt   = '0;
          err_nxt   = 2'b00;
          state_nxt = WR_N;
        end
      end
      WR_N: state_nxt = RD_N;
      RD_N: begin
        if (bus.readdata != angle_q) begin
          err_nxt   = 2'b01;
          state_nxt = OUT;
        end else begin
          state_nxt = WR_START;
        end
      end
      WR_START: begin
        poll_cnt_nxt = '0;
        state_nxt    = POLL;
      end
      POLL: begin
        poll_cnt_nxt = poll_inc;
        gap_cnt_nxt  = '0;
        if (bus.readdata[0]) begin
          state_nxt = RD_FN1;
        end else if (poll_inc == POLL_LAST) begin
          err_nxt   = 2'b10;
          fn1_nxt   = '0;
          fn2_nxt   = '0;
          state_nxt = CLR;
        end else if (POLL_GAP == 0) begin
          state_nxt = POLL;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = POLL;
        else                     gap_cnt_nxt = gap_cnt + 1'b1;
      end
      RD_FN1: begin
        fn1_nxt   = bus.readdata;
        state_nxt = RD_FN2;
      end
      RD_FN2: begin
        fn2_nxt   = bus.readdata;
        state_nxt = CLR;
      end
      CLR: state_nxt = OUT;
      OUT: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being entered.
    case (state_nxt)
      WR_N:     begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_ANGLE; wd_nxt = angle_nxt; end
      RD_N:     begin cs_nxt = 1'b1; addr_nxt = A_ANGLE; end
      WR_START: begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_START; end
      POLL:     begin cs_nxt = 1'b1; addr_nxt = A_DONE; end
      RD_FN1:   begin cs_nxt = 1'b1; addr_nxt = A_FN1; end
      RD_FN2:   begin cs_nxt = 1'b1; addr_nxt = A_FN2; end
      CLR:      begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = A_DONE; end
      default:  ;
    endcase
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.res_valid  = (state == OUT);
  assign bus.busy       = (state != IDLE);
  assign bus.res_fn1    = fn1_q;
  assign bus.res_fn2    = fn2_q;
  assign bus.res_err    = err_q;
  assign bus.chipselect = cs_q;
  assign bus.write_n    = wn_q;
  assign bus.address    = addr_q;
  assign bus.writedata  = wd_q;
endmodule

// File: tb/tb_avmm_cordic_master.sv
// Scoreboard bench: randomized commands against a register-level slave model and
// a cycle-count reference model of the expected bus sequence and result.
module tb_avmm_cordic_master;
  localparam int W = 32;
  localparam int G = 2;
  localparam int M = 4;

  typedef struct {
    logic [W-1:0] fn1;
    logic [W-1:0] fn2;
    logic [1:0]   err;
    int           polls;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  avmm_cordic_master_if #(.WIDTH(W)) bus ();

  avmm_cordic_master #(.WIDTH(W), .POLL_GAP(G), .MAX_POLLS(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [W-1:0] s_angle = '0;
  logic [W-1:0] s_fn1 = '0;
  logic [W-1:0] s_fn2 = '0;
  logic [W-1:0] s_corrupt = '0;
  int           s_delay = 1;
  int           s_done_at = 0;
  bit           s_armed = 1'b0;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0: bus.readdata = s_angle ^ s_corrupt;
      3'd2: bus.readdata = s_fn1;
      3'd3: bus.readdata = s_fn2;
      3'd4: bus.readdata = {{(W-1){1'b0}}, (s_armed && (cyc >= s_done_at))};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (bus.chipselect && !bus.write_n) begin
      case (bus.address)
        3'd0: s_angle <= bus.writedata;
        3'd1: begin s_armed <= 1'b1; s_done_at <= cyc + s_delay; end
        3'd4: s_armed <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, required event not seen (cycle %0d)", name, cyc);
  endtask

  // Reference model: done becomes visible delay cycles after the start write;
  // polls occur one cycle after start and every G+1 cycles after that.
  function automatic exp_t model(input logic [W-1:0] f1, input logic [W-1:0] f2,
                                 input int delay, input logic [W-1:0] corrupt);
    exp_t e;
    int   n;
    e.fn1 = '0; e.fn2 = '0; e.polls = 0; e.err = 2'b00; e.lat = 0;
    if (corrupt != '0) begin
      e.err = 2'b01;
      e.lat = 3;
    end else begin
      n = (delay <= 1) ? 1 : (delay - 1 + G) / (G + 1) + 1;
      if (n > M) begin
        e.err = 2'b10; e.polls = M; e.lat = 6 + (M - 1) * (G + 1);
      end else begin
        e.fn1 = f1; e.fn2 = f2; e.polls = n; e.lat = 8 + (n - 1) * (G + 1);
      end
    end
    return e;
  endfunction

  exp_t         sb[$];
  logic [3:0]   txq[$];
  int           pollq[$];
  logic [3:0]   eseq[$];

  // ---------------- monitor ----------------
  bit           in_flight = 0;
  bit           held = 0;
  bit           expect_low = 0;
  bit           idle_bad = 0;
  int           fire_cyc = 0;
  logic [W-1:0] cap_fn1, cap_fn2;
  logic [1:0]   cap_err;

  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0; held = 0; expect_low = 0;
    end else begin
      if (bus.chipselect) begin
        txq.push_back({bus.write_n, bus.address});
        if (bus.write_n && bus.address == 3'd4) pollq.push_back(cyc);
      end else if (bus.write_n !== 1'b1 || bus.address !== 3'd0 || bus.writedata !== '0) begin
        idle_bad = 1;
      end

      if (expect_low) begin
        check("valid_drop", 64'(bus.res_valid), 64'(0));
        check("ready_after_out", 64'(bus.cmd_ready), 64'(1));
        expect_low = 0;
      end else if (in_flight) begin
        check("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
        if (bus.res_valid) begin
          if (!held) begin
            if (sb.size() == 0) begin
              fail_now("sb_empty");
            end else begin
              exp_t e;
              bit   ok;
              e = sb.pop_front();
              check("latency", 64'(cyc - fire_cyc), 64'(e.lat));
              check("res_fn1", 64'(bus.res_fn1), 64'(e.fn1));
              check("res_fn2", 64'(bus.res_fn2), 64'(e.fn2));
              check("res_err", 64'(bus.res_err), 64'(e.err));
              eseq.delete();
              eseq.push_back(4'h0);
              eseq.push_back(4'h8);
              if (e.err != 2'b01) begin
                eseq.push_back(4'h1);
                for (int i = 0; i < e.polls; i++) eseq.push_back(4'hC);
                if (e.err == 2'b00) begin eseq.push_back(4'hA); eseq.push_back(4'hB); end
                eseq.push_back(4'h4);
              end
              ok = (txq.size() == eseq.size());
              for (int i = 0; ok && i < eseq.size(); i++) if (txq[i] !== eseq[i]) ok = 0;
              check("bus_seq_len", 64'(txq.size()), 64'(eseq.size()));
              check("bus_seq_ok", 64'(ok), 64'(1));
              if (pollq.size() > 1) begin
                ok = 1;
                for (int i = 1; i < pollq.size(); i++) if (pollq[i] - pollq[i-1] != G + 1) ok = 0;
                check("poll_spacing", 64'(ok), 64'(1));
              end
              check("idle_bus", 64'(idle_bad), 64'(0));
            end
          end else begin
            check("hold_fn1", 64'(bus.res_fn1), 64'(cap_fn1));
            check("hold_fn2", 64'(bus.res_fn2), 64'(cap_fn2));
            check("hold_err", 64'(bus.res_err), 64'(cap_err));
          end
          cap_fn1 = bus.res_fn1; cap_fn2 = bus.res_fn2; cap_err = bus.res_err;
          if (bus.res_ready) begin in_flight = 0; held = 0; expect_low = 1; end
          else held = 1;
        end
      end else if (bus.res_valid) begin
        fail_now("spurious_res_valid");
      end

      if (bus.cmd_valid && bus.cmd_ready) begin
        in_flight = 1; fire_cyc = cyc; idle_bad = 0;
        txq.delete(); pollq.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_cmd(input logic [W-1:0] angle, input logic [W-1:0] f1, input logic [W-1:0] f2,
                         input int delay, input logic [W-1:0] corrupt,
                         input bit hold_ready, input bit keep_valid);
    int k;
    s_fn1 = f1; s_fn2 = f2; s_delay = delay; s_corrupt = corrupt;
    bus.cmd_angle = angle;
    bus.cmd_valid = 1'b1;
    bus.res_ready = !hold_ready;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (k == 50) begin fail_now("cmd_fire"); bus.cmd_valid = 1'b0; return; end
    sb.push_back(model(f1, f2, delay, corrupt));
    @(posedge clk); #1;
    if (keep_valid) bus.cmd_angle = ~angle;
    else            bus.cmd_valid = 1'b0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.res_valid) break;
    end
    if (k == 300) begin fail_now("res_valid_wait"); bus.cmd_valid = 1'b0; return; end
    if (hold_ready) begin
      repeat (10) @(posedge clk);
      #1 bus.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_angle = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("rst_res_valid", 64'(bus.res_valid), 64'(0));
    check("rst_fn1", 64'(bus.res_fn1), 64'(0));
    check("rst_fn2", 64'(bus.res_fn2), 64'(0));
    check("rst_err", 64'(bus.res_err), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_cs", 64'(bus.chipselect), 64'(0));
    check("rst_write_n", 64'(bus.write_n), 64'(1));
    check("rst_addr", 64'(bus.address), 64'(0));
    check("rst_wdata", 64'(bus.writedata), 64'(0));
    @(posedge clk); #1;

    run_cmd(32'h0000_2D00, 32'h0000_5A82, 32'h0000_5A82, 3, '0, 0, 0);
    run_cmd($urandom, $urandom, $urandom, 1, '0, 0, 0);
    run_cmd(32'h0000_2D00, $urandom, $urandom, 3, 32'h0000_0001, 0, 0);
    run_cmd($urandom, $urandom, $urandom, 1000, '0, 0, 0);
    run_cmd($urandom, $urandom, $urandom, 2, '0, 1, 1);
    run_cmd($urandom, $urandom, $urandom, 0, '0, 0, 0);

    // Reset while waiting between polls
    s_delay = 1000; s_corrupt = '0;
    bus.cmd_angle = $urandom;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    for (k = 0; k < 50; k++) begin @(negedge clk); if (bus.cmd_ready) break; end
    if (k == 50) fail_now("rst_test_fire");
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.chipselect && bus.write_n && bus.address == 3'd4) break;
    end
    if (k == 50) fail_now("rst_test_poll");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("midrst_cs", 64'(bus.chipselect), 64'(0));
    check("midrst_res_valid", 64'(bus.res_valid), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_err", 64'(bus.res_err), 64'(0));
    @(posedge clk); #1;
    run_cmd($urandom, $urandom, $urandom, 3, '0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] cor;
      cor = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      run_cmd($urandom, $urandom, $urandom, int'($urandom_range(0, 13)), cor,
              ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required end of test not seen");
    $fatal(1, "watchdog");
  end
endmodule
